// File: rtl/zap_wb_rr_arbiter_pkg.sv
// Shared types and constants for the ZAP Wishbone round-robin arbiter.
// Holds the CTI encodings, the arbiter FSM state type and the bundled master request.
package zap_wb_rr_arbiter_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] adr;
    logic [2:0]  cti;
  } wb_req_t;

  // A beat may end an ownership only if it is not inside an incrementing/constant burst.
  function automatic logic is_boundary(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/zap_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, searching upward and wrapping.
module zap_rr_pick #(
  parameter  int NUM_MASTERS = 3,
  localparam int PTR_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [PTR_W-1:0]       winner,
  output logic                   any
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(ptr) + i) % NUM_MASTERS;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = idx[PTR_W-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/zap_wb_rr_arbiter.sv
// N-master Wishbone B3 arbiter in front of zap_wb_adapter: registered round-robin grants,
// ownership for a full CYC, preemption only on a transfer boundary after MAX_BEATS acks.
module zap_wb_rr_arbiter
  import zap_wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_BEATS   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_cyc,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_stb,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_we,
  input  logic [4*NUM_MASTERS-1:0]  i_m_wb_sel,
  input  logic [32*NUM_MASTERS-1:0] i_m_wb_dat,
  input  logic [32*NUM_MASTERS-1:0] i_m_wb_adr,
  input  logic [3*NUM_MASTERS-1:0]  i_m_wb_cti,
  output logic [NUM_MASTERS-1:0]    o_m_wb_ack,
  output logic [31:0]               o_m_wb_dat,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [3:0]                o_wb_sel,
  output logic [31:0]               o_wb_dat,
  output logic [31:0]               o_wb_adr,
  output logic [2:0]                o_wb_cti,
  input  logic                      i_wb_ack,
  input  logic [31:0]               i_wb_dat,
  output logic [NUM_MASTERS-1:0]    o_grant
);

  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_BEATS + 2);

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [PTR_W-1:0]       pick_winner;
  logic                   pick_any;

  wb_req_t own_req, bus_req;
  logic    others_wait, preempt;

  zap_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req    (i_m_wb_cyc),
    .ptr    (ptr_q),
    .gnt    (pick_gnt),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_comb begin
    own_req.cyc = i_m_wb_cyc[owner_q];
    own_req.stb = i_m_wb_stb[owner_q];
    own_req.we  = i_m_wb_we[owner_q];
    own_req.sel = i_m_wb_sel[owner_q*4 +: 4];
    own_req.dat = i_m_wb_dat[owner_q*32 +: 32];
    own_req.adr = i_m_wb_adr[owner_q*32 +: 32];
    own_req.cti = i_m_wb_cti[owner_q*3 +: 3];
  end

  // grant_q is only non-zero while owning, so it doubles as the owner mask here.
  assign others_wait = |(i_m_wb_cyc & ~grant_q);
  assign preempt     = (MAX_BEATS != 0) && i_wb_ack && (int'(cnt_q) + 1 >= MAX_BEATS) &&
                       is_boundary(own_req.cti) && others_wait;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_any) begin
          state_d = ST_OWN;
          grant_d = pick_gnt;
          owner_d = pick_winner;
          ptr_d   = (int'(pick_winner) == NUM_MASTERS - 1) ? '0 : pick_winner + PTR_W'(1);
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_OWN: begin
        if (i_wb_ack && int'(cnt_q) < MAX_BEATS) cnt_d = cnt_q + CNT_W'(1);
        if (!own_req.cyc || preempt) begin
          state_d = ST_GAP;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign bus_req    = (state_q == ST_OWN) ? own_req : '0;
  assign o_wb_cyc   = bus_req.cyc;
  assign o_wb_stb   = bus_req.stb;
  assign o_wb_we    = bus_req.we;
  assign o_wb_sel   = bus_req.sel;
  assign o_wb_dat   = bus_req.dat;
  assign o_wb_adr   = bus_req.adr;
  assign o_wb_cti   = bus_req.cti;
  assign o_m_wb_ack = (state_q == ST_OWN && i_wb_ack) ? grant_q : '0;
  assign o_m_wb_dat = i_wb_dat;
  assign o_grant    = grant_q;

endmodule

// File: tb/tb_zap_wb_rr_arbiter.sv
// Bench for zap_wb_rr_arbiter: three instances (MAX_BEATS 4, 2, 0), each checked every cycle
// against an ownership-level model, plus hand-computed expectations on grant order and timing.
module tb_zap_wb_rr_arbiter;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic        rst;
  logic [2:0]  m_cyc [3], m_stb [3], m_we [3];
  logic [11:0] m_sel [3];
  logic [95:0] m_dat [3], m_adr [3];
  logic [8:0]  m_cti [3];
  logic [2:0]  m_ack [3], grant [3];
  logic [31:0] m_rdat [3];
  logic        wb_cyc [3], wb_stb [3], wb_we [3];
  logic [3:0]  wb_sel [3];
  logic [31:0] wb_dat [3], wb_adr [3];
  logic [2:0]  wb_cti [3];
  logic        wack [3];
  logic [2:0]  ack_auto, ack_force;
  logic [31:0] rdat;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int MB = (g == 0) ? 4 : ((g == 1) ? 2 : 0);
    // Slave acks every strobed beat; ack_force injects acks regardless of STB.
    assign wack[g] = ack_force[g] | (ack_auto[g] & wb_stb[g]);
    zap_wb_rr_arbiter #(.NUM_MASTERS(3), .MAX_BEATS(MB)) u_dut (
      .i_clk(clk), .i_reset(rst),
      .i_m_wb_cyc(m_cyc[g]), .i_m_wb_stb(m_stb[g]), .i_m_wb_we(m_we[g]),
      .i_m_wb_sel(m_sel[g]), .i_m_wb_dat(m_dat[g]), .i_m_wb_adr(m_adr[g]),
      .i_m_wb_cti(m_cti[g]), .o_m_wb_ack(m_ack[g]), .o_m_wb_dat(m_rdat[g]),
      .o_wb_cyc(wb_cyc[g]), .o_wb_stb(wb_stb[g]), .o_wb_we(wb_we[g]),
      .o_wb_sel(wb_sel[g]), .o_wb_dat(wb_dat[g]), .o_wb_adr(wb_adr[g]),
      .o_wb_cti(wb_cti[g]), .i_wb_ack(wack[g]), .i_wb_dat(rdat),
      .o_grant(grant[g])
    );
  end

  function automatic int mb(int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 0);
  endfunction

  // ---------------- master stimulus: beats left, burst length, position ----------------
  int left [3][3], blen [3][3], pos [3][3];
  bit seen [3][3];

  task automatic drive();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        m_cyc[i][k] = (left[i][k] > 0);
        m_stb[i][k] = (left[i][k] > 0);
        m_we[i][k]  = (k == 1);
        m_sel[i][k*4 +: 4]   = (k == 0) ? 4'hF : ((k == 1) ? 4'h3 : 4'hC);
        m_dat[i][k*32 +: 32] = 32'hD000_0000 + 32'(k * 16 + pos[i][k]);
        m_adr[i][k*32 +: 32] = 32'(32'h100 * (k + 1) + pos[i][k] * 4);
        m_cti[i][k*3 +: 3]   = (blen[i][k] == 1) ? 3'b000 :
                               ((pos[i][k] == blen[i][k] - 1) ? 3'b111 : 3'b010);
      end
  endtask

  task automatic job(int i, int k, int beats, int bl);
    left[i][k] = beats;
    blen[i][k] = bl;
    pos[i][k]  = 0;
    drive();
  endtask

  task automatic clear_jobs();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        left[i][k] = 0; blen[i][k] = 1; pos[i][k] = 0;
      end
    drive();
  endtask

  // One clock: sample acks mid-cycle, then advance the masters just after the edge.
  task automatic cyc1();
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) seen[i][k] = m_ack[i][k];
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++)
        if (seen[i][k] && left[i][k] > 0) begin
          left[i][k]--;
          pos[i][k] = (pos[i][k] + 1) % blen[i][k];
        end
    drive();
  endtask

  task automatic run(int n);
    for (int c = 0; c < n; c++) cyc1();
  endtask

  // ---------------- literal expectations, checked at the next falling edge ----------------
  typedef struct {
    string       name;
    int          inst;
    int          fld;
    int          idx;
    logic [31:0] exp;
  } lit_t;
  lit_t lit_q[$];

  task automatic want(string name, int i, int f, int idx, logic [31:0] e);
    lit_t t;
    t.name = name; t.inst = i; t.fld = f; t.idx = idx; t.exp = e;
    lit_q.push_back(t);
  endtask

  // Observation logs: successive owners, idle cycles before each, master0 acks.
  int         glog [3][8], gaplog [3][8], glen [3], zrun [3], m0acks [3], m0b4 [3];
  logic [2:0] prevg [3];

  function automatic logic [31:0] field(int i, int f, int idx);
    case (f)
      0: return 32'(grant[i]);
      1: return 32'(m_ack[i]);
      2: return 32'(wb_cyc[i]);
      3: return wb_adr[i];
      4: return m_rdat[i];
      5: return (idx < glen[i]) ? 32'(glog[i][idx]) : 32'hFFFF_FFFF;
      6: return (idx < glen[i]) ? 32'(gaplog[i][idx]) : 32'hFFFF_FFFF;
      7: return 32'(m0b4[i]);
      8: return 32'(m0acks[i]);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // ---------------- ownership model and compare process ----------------
  int           nchk = 0, nbad = 0;
  int           md_own [3] = '{-1, -1, -1};
  int           md_ptr [3] = '{0, 0, 0};
  int           md_beats [3] = '{0, 0, 0};
  bit           armed = 1'b0;
  int           o, k;
  bit           acked, waiting, bnd, pre;
  logic [111:0] act, expv;
  logic [31:0]  fv;
  lit_t         e;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      o = md_own[i];
      if (o >= 0)
        expv = {3'(1 << o), wack[i] ? 3'(1 << o) : 3'b000, m_cyc[i][o], m_stb[i][o], m_we[i][o],
                m_sel[i][o*4 +: 4], m_dat[i][o*32 +: 32], m_adr[i][o*32 +: 32],
                m_cti[i][o*3 +: 3], rdat};
      else
        expv = {3'b000, 3'b000, 3'b000, 4'h0, 32'h0, 32'h0, 3'b000, rdat};
      act = {grant[i], m_ack[i], wb_cyc[i], wb_stb[i], wb_we[i], wb_sel[i], wb_dat[i],
             wb_adr[i], wb_cti[i], m_rdat[i]};
      if (armed) begin
        nchk++;
        if (act !== expv) begin
          nbad++;
          $display("FAIL model inst%0d t=%0t: got %h want %h", i, $time, act, expv);
        end
      end

      if (rst) begin
        glen[i] = 0; zrun[i] = 0; m0acks[i] = 0; m0b4[i] = -1; prevg[i] = 3'b000;
      end else begin
        if (m_ack[i][0] === 1'b1) m0acks[i]++;
        if (grant[i] == 3'b000) zrun[i]++;
        else if (grant[i] != prevg[i]) begin
          if (glen[i] < 8) begin
            glog[i][glen[i]]   = int'(grant[i]);
            gaplog[i][glen[i]] = zrun[i];
            glen[i]++;
          end
          zrun[i] = 0;
          if (grant[i] == 3'b010 && m0b4[i] < 0) m0b4[i] = m0acks[i];
        end
        prevg[i] = grant[i];
      end

      // Advance the model to the state after the coming rising edge.
      if (rst) begin
        md_own[i] = -1; md_ptr[i] = 0; md_beats[i] = 0;
      end else if (o >= 0) begin
        acked   = wack[i];
        waiting = (m_cyc[i] & ~3'(1 << o)) != 3'b000;
        bnd     = (m_cti[i][o*3 +: 3] == 3'b000) || (m_cti[i][o*3 +: 3] == 3'b111);
        pre     = (mb(i) > 0) && acked && (md_beats[i] + 1 >= mb(i)) && bnd && waiting;
        if (acked && md_beats[i] < mb(i)) md_beats[i]++;
        if (!m_cyc[i][o] || pre) md_own[i] = -1;
      end else begin
        for (int off = 0; off < 3; off++) begin
          k = (md_ptr[i] + off) % 3;
          if (md_own[i] < 0 && m_cyc[i][k]) begin
            md_own[i] = k; md_ptr[i] = (k + 1) % 3; md_beats[i] = 0;
          end
        end
      end
    end

    while (lit_q.size() > 0) begin
      e  = lit_q.pop_front();
      fv = field(e.inst, e.fld, e.idx);
      nchk++;
      if (fv !== e.exp) begin
        nbad++;
        $display("FAIL %s inst%0d: got %h want %h", e.name, e.inst, fv, e.exp);
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic do_reset();
    clear_jobs();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; ack_auto = 3'b111; ack_force = 3'b001; rdat = 32'h0;
    clear_jobs();
    cyc1();
    want("rst_grant", 0, 0, 0, 32'h0);
    want("rst_cyc",   0, 2, 0, 32'h0);
    want("rst_ack",   0, 1, 0, 32'h0);
    cyc1();
    ack_force = 3'b000; rst = 1'b0;

    // 1: single classic read by master0
    rdat = 32'hDEAD_BEEF;
    job(0, 0, 1, 1);
    want("t1_pre_grant", 0, 0, 0, 32'h0);
    cyc1();
    want("t1_grant", 0, 0, 0, 32'h1);
    want("t1_cyc",   0, 2, 0, 32'h1);
    want("t1_adr",   0, 3, 0, 32'h100);
    want("t1_ack",   0, 1, 0, 32'h1);
    want("t1_rdat",  0, 4, 0, 32'hDEAD_BEEF);
    cyc1();
    want("t1_drop_cyc", 0, 2, 0, 32'h0);
    cyc1();
    want("t1_gap_grant", 0, 0, 0, 32'h0);
    run(2);

    // 2: all three request at reset release
    clear_jobs();
    rst = 1'b1;
    job(0, 0, 1, 1); job(0, 1, 1, 1); job(0, 2, 1, 1);
    run(2);
    rst = 1'b0;
    run(14);
    want("t2_own0", 0, 5, 0, 32'h1);
    want("t2_own1", 0, 5, 1, 32'h2);
    want("t2_own2", 0, 5, 2, 32'h4);
    want("t2_gap1", 0, 6, 1, 32'h1);
    want("t2_gap2", 0, 6, 2, 32'h1);
    cyc1();

    // 3: after master1 served, masters 0 and 2 together -> 2 then 0
    do_reset();
    job(0, 1, 1, 1);
    run(6);
    job(0, 0, 1, 1); job(0, 2, 1, 1);
    run(12);
    want("t3_own0", 0, 5, 0, 32'h2);
    want("t3_own1", 0, 5, 1, 32'h4);
    want("t3_own2", 0, 5, 2, 32'h1);
    cyc1();

    // 4: preemption after a 4-beat burst (MAX_BEATS=4)
    do_reset();
    job(0, 0, 8, 4); job(0, 1, 1, 1);
    run(20);
    want("t4_own0",   0, 5, 0, 32'h1);
    want("t4_own1",   0, 5, 1, 32'h2);
    want("t4_own2",   0, 5, 2, 32'h1);
    want("t4_m0b4",   0, 7, 0, 32'd4);
    want("t4_gap1",   0, 6, 1, 32'h1);
    want("t4_m0acks", 0, 8, 0, 32'd8);
    cyc1();

    // 5: boundary rule; MAX_BEATS=2 waits for EOB, MAX_BEATS=0 never preempts
    do_reset();
    job(1, 0, 16, 8); job(1, 1, 1, 1);
    job(2, 0, 16, 8); job(2, 1, 1, 1);
    run(30);
    want("t5_mb2_m0b4", 1, 7, 0, 32'd8);
    want("t5_mb2_own2", 1, 5, 2, 32'h1);
    want("t5_mb0_m0b4", 2, 7, 0, 32'd16);
    want("t5_mb0_own1", 2, 5, 1, 32'h2);
    want("t5_mb0_len",  2, 5, 2, 32'hFFFF_FFFF);
    cyc1();

    // 6: reset during an acked beat; next arbitration starts from ptr=0
    do_reset();
    job(0, 0, 4, 4);
    run(2);
    ack_force[0] = 1'b1;
    rst = 1'b1;
    cyc1();
    want("t6_grant", 0, 0, 0, 32'h0);
    want("t6_cyc",   0, 2, 0, 32'h0);
    want("t6_ack",   0, 1, 0, 32'h0);
    clear_jobs();
    job(0, 0, 1, 1); job(0, 2, 1, 1);
    cyc1();
    rst = 1'b0; ack_force = 3'b000;
    cyc1();
    want("t6_regrant", 0, 0, 0, 32'h1);
    run(8);
    want("t6_own0", 0, 5, 0, 32'h1);
    want("t6_own1", 0, 5, 1, 32'h4);
    cyc1();

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/zap_wb_rr_arbiter.md
Name: zap_wb_rr_arbiter

Overview:
- N-master Wishbone B3 arbiter that shares the single external ZAP bus between the merged core port, a DMA engine and future masters.
- Grants are round-robin and registered. Ownership holds for the full cycle (CYC) of the granted master.
- A master is preempted only at a transfer boundary, once it has used MAX_BEATS acks while another master is waiting.
- Sits between the masters and zap_wb_adapter; its outputs drive the adapter's I_WB_* inputs.

Parameters:
- NUM_MASTERS, 3, number of requesting masters; legal range is 2 or more.
- MAX_BEATS, 16, acks allowed per grant before preemption becomes eligible; 0 disables preemption.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_m_wb_cyc  in  NUM_MASTERS  per-master CYC (this is the request)
- i_m_wb_stb  in  NUM_MASTERS  per-master STB
- i_m_wb_we  in  NUM_MASTERS  per-master WE
- i_m_wb_sel  in  4*NUM_MASTERS  per-master SEL, master k at [4k+3:4k]
- i_m_wb_dat  in  32*NUM_MASTERS  per-master write data
- i_m_wb_adr  in  32*NUM_MASTERS  per-master address
- i_m_wb_cti  in  3*NUM_MASTERS  per-master CTI
- o_m_wb_ack  out  NUM_MASTERS  per-master ACK
- o_m_wb_dat  out  32  read data, broadcast to all masters
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  shared bus control
- o_wb_sel  out  4  shared bus byte select
- o_wb_dat  out  32  shared bus write data
- o_wb_adr  out  32  shared bus address
- o_wb_cti  out  3  shared bus CTI
- i_wb_ack  in  1  shared bus ACK
- i_wb_dat  in  32  shared bus read data
- o_grant  out  NUM_MASTERS  one-hot current owner; all zero when the bus is unowned

Behaviour:

FSM states: IDLE, OWN, GAP.

IDLE:
- If any i_m_wb_cyc is high, pick the first requester at or after ptr, searching upward and wrapping.
- Register o_grant to that master, set ptr to winner+1 (mod NUM_MASTERS), clear beat_cnt, go to OWN.
- Grant latency: request sampled at edge t gives o_wb_cyc at t+1.

OWN (owner k):
- o_wb_cyc/stb/we/sel/dat/adr/cti are a combinational mux of master k's signals.
- o_m_wb_ack[k] = i_wb_ack. All other acks are 0.
- beat_cnt increments on every i_wb_ack and saturates at MAX_BEATS.
- Transition to GAP when either:
  - i_m_wb_cyc[k] = 0, or
  - preempt condition holds: MAX_BEATS != 0, and beat_cnt+1 >= MAX_BEATS on an acked beat whose CTI is 000 or 111, and some other master's cyc is high.
- Preemption never happens mid-burst (CTI 001/010). The condition is rechecked on every subsequent boundary beat.

GAP:
- One cycle with o_wb_cyc = o_wb_stb = 0 and o_grant = 0, guaranteeing CYC deassertion between owners.
- Arbitrates exactly as IDLE does: a request goes directly to OWN, otherwise go to IDLE.
- A preempted master keeps its CYC high. It sees no ACK and is re-arbitrated normally; its turn comes after the ptr rotation.

Outputs outside OWN:
- All o_wb_* are 0. o_m_wb_ack is all zero; a stray i_wb_ack is dropped.
- o_m_wb_dat = i_wb_dat always.

Reset:
- At the edge where i_reset is sampled high: state=IDLE, ptr=0, beat_cnt=0, o_grant=0.
- Consequently o_wb_* = 0 and o_m_wb_ack = 0.
- Reset mid-burst abandons the transfer; no ack is forwarded in the following cycle.

Decomposition:
- Add to zap_localparams.svh:
  - CTI_CLASSIC = 3'b000, CTI_CONST = 3'b001, CTI_INCR = 3'b010, CTI_EOB = 3'b111.
  - The IDLE/OWN/GAP state encoding.
- Sub-module zap_rr_pick: combinational rotating-priority picker.
  - Inputs: req[NUM_MASTERS], ptr.
  - Outputs: one-hot gnt, winner index, any.
  - Reused by the FSM in both the IDLE and GAP paths.

Test Plan:
1. Single classic read: master0 cyc/stb, adr=0x100, at t0 -> o_wb_cyc=1 and o_grant=3'b001 at t1. i_wb_ack with i_wb_dat=0xDEADBEEF -> o_m_wb_ack=001, o_m_wb_dat=0xDEADBEEF. cyc dropped -> one GAP cycle, then IDLE.
2. All three masters request at reset release, each doing one classic beat -> grants 001, 010, 100 in order, with exactly one o_wb_cyc=0 cycle between owners.
3. Round robin: after master1 is served (ptr=2), masters 0 and 2 request together -> master2 granted first, then master0.
4. Preemption (MAX_BEATS=4): master0 holds cyc for repeated 4-beat bursts (CTI 010,010,010,111) while master1 requests -> GAP after the 4th ack, then o_grant=010. Master0 gets zero acks until master1 drops cyc.
5. Boundary rule (MAX_BEATS=2, master0 8-beat incrementing burst, master1 waiting) -> no GAP until the CTI=111 ack; beat 8 is the last master0 ack. With MAX_BEATS=0 the same stimulus -> master0 retains the bus until its cyc drops.
6. i_reset asserted during OWN with stb high and i_wb_ack high -> next cycle o_wb_cyc=0, o_grant=0, o_m_wb_ack=0; the next request is arbitrated from ptr=0.
